// File: rtl/collision_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : collision_scheduler
// Brief    : Per-frame collision/pocketing scheduler for the white and red balls.
// Revision : 1.0 - initial release
// ============================================================================

module collision_ball #(
    parameter int HOLE_SINK_FRAMES = 16
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               i_sof,
    input  logic               i_border_req,
    input  logic signed [10:0] i_border_vel_x,
    input  logic signed [10:0] i_border_vel_y,
    input  logic               i_bb_req,
    input  logic signed [10:0] i_bb_vel_x,
    input  logic signed [10:0] i_bb_vel_y,
    input  logic               i_hole_req,
    input  logic [2:0]         i_hole_idx,
    input  logic               i_respawn_req,
    output logic signed [10:0] o_vel_x,
    output logic signed [10:0] o_vel_y,
    output logic               o_vel_load,
    output logic [1:0]         o_state,
    output logic [2:0]         o_hole_num,
    output logic               o_respawn
);
    typedef enum logic [1:0] {
        ST_ACTIVE   = 2'b00,
        ST_SINKING  = 2'b01,
        ST_POCKETED = 2'b10
    } state_t;

    localparam logic [7:0] c_sink_frames = 8'(HOLE_SINK_FRAMES);

    state_t             r_state;
    logic               r_col_pend;
    logic signed [10:0] r_col_x;
    logic signed [10:0] r_col_y;
    logic               r_hole_pend;
    logic [2:0]         r_hole_idx;
    logic [2:0]         r_hole_num;
    logic [7:0]         r_cnt;
    logic signed [10:0] r_vel_x;
    logic signed [10:0] r_vel_y;
    logic               r_vel_load;
    logic               r_respawn;

    logic               w_col_req;
    logic signed [10:0] w_col_x;
    logic signed [10:0] w_col_y;
    logic [7:0]         w_cnt_next;

    // Ball-ball impact takes priority over a simultaneous border bounce.
    assign w_col_req  = i_bb_req | i_border_req;
    assign w_col_x    = i_bb_req ? i_bb_vel_x : i_border_vel_x;
    assign w_col_y    = i_bb_req ? i_bb_vel_y : i_border_vel_y;
    assign w_cnt_next = r_cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_state     <= ST_ACTIVE;
            r_col_pend  <= 1'b0;
            r_col_x     <= '0;
            r_col_y     <= '0;
            r_hole_pend <= 1'b0;
            r_hole_idx  <= '0;
            r_hole_num  <= '0;
            r_cnt       <= '0;
            r_vel_x     <= '0;
            r_vel_y     <= '0;
            r_vel_load  <= 1'b0;
            r_respawn   <= 1'b0;
        end else begin
            r_vel_load <= 1'b0;
            r_respawn  <= 1'b0;
            unique case (r_state)
                ST_ACTIVE: begin
                    if (i_sof) begin
                        // Boundary cycle: resolve last frame, then re-arm with this cycle's requests.
                        r_col_pend  <= w_col_req;
                        r_col_x     <= w_col_x;
                        r_col_y     <= w_col_y;
                        r_hole_pend <= i_hole_req;
                        r_hole_idx  <= i_hole_idx;
                        if (r_hole_pend) begin
                            r_state     <= ST_SINKING;
                            r_hole_num  <= r_hole_idx;
                            r_cnt       <= '0;
                            r_vel_load  <= 1'b1;
                            r_vel_x     <= '0;
                            r_vel_y     <= '0;
                            r_col_pend  <= 1'b0;
                            r_hole_pend <= 1'b0;
                        end else if (r_col_pend) begin
                            r_vel_load <= 1'b1;
                            r_vel_x    <= r_col_x;
                            r_vel_y    <= r_col_y;
                        end
                    end else begin
                        if (!r_col_pend && w_col_req) begin
                            r_col_pend <= 1'b1;
                            r_col_x    <= w_col_x;
                            r_col_y    <= w_col_y;
                        end
                        if (!r_hole_pend && i_hole_req) begin
                            r_hole_pend <= 1'b1;
                            r_hole_idx  <= i_hole_idx;
                        end
                    end
                end
                ST_SINKING: begin
                    if (i_sof) begin
                        r_cnt <= w_cnt_next;
                        if (w_cnt_next == c_sink_frames) begin
                            r_state <= ST_POCKETED;
                        end
                    end
                end
                ST_POCKETED: begin
                    if (i_respawn_req) begin
                        r_state   <= ST_ACTIVE;
                        r_respawn <= 1'b1;
                    end
                end
                default: r_state <= ST_ACTIVE;
            endcase
        end
    end

    assign o_vel_x    = r_vel_x;
    assign o_vel_y    = r_vel_y;
    assign o_vel_load = r_vel_load;
    assign o_state    = r_state;
    assign o_hole_num = r_hole_num;
    assign o_respawn  = r_respawn;
endmodule

module collision_scheduler #(
    parameter int HOLE_SINK_FRAMES = 16
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               whiteBorderReq,
    input  logic               redBorderReq,
    input  logic signed [10:0] whiteBorderVelX,
    input  logic signed [10:0] whiteBorderVelY,
    input  logic signed [10:0] redBorderVelX,
    input  logic signed [10:0] redBorderVelY,
    input  logic               ballBallReq,
    input  logic signed [10:0] ballBallWhiteVelX,
    input  logic signed [10:0] ballBallWhiteVelY,
    input  logic signed [10:0] ballBallRedVelX,
    input  logic signed [10:0] ballBallRedVelY,
    input  logic               whiteHoleReq,
    input  logic               redHoleReq,
    input  logic [2:0]         whiteHoleIdx,
    input  logic [2:0]         redHoleIdx,
    input  logic               whiteRespawnReq,
    input  logic               redRespawnReq,
    output logic signed [10:0] whiteVelXOut,
    output logic signed [10:0] whiteVelYOut,
    output logic signed [10:0] redVelXOut,
    output logic signed [10:0] redVelYOut,
    output logic               whiteVelLoad,
    output logic               redVelLoad,
    output logic [1:0]         whiteState,
    output logic [1:0]         redState,
    output logic [2:0]         whiteHoleNum,
    output logic [2:0]         redHoleNum,
    output logic               whiteRespawn,
    output logic               redRespawn
);
    collision_ball #(.HOLE_SINK_FRAMES(HOLE_SINK_FRAMES)) u_white (
        .clk           (clk),
        .resetN        (resetN),
        .i_sof         (startOfFrame),
        .i_border_req  (whiteBorderReq),
        .i_border_vel_x(whiteBorderVelX),
        .i_border_vel_y(whiteBorderVelY),
        .i_bb_req      (ballBallReq),
        .i_bb_vel_x    (ballBallWhiteVelX),
        .i_bb_vel_y    (ballBallWhiteVelY),
        .i_hole_req    (whiteHoleReq),
        .i_hole_idx    (whiteHoleIdx),
        .i_respawn_req (whiteRespawnReq),
        .o_vel_x       (whiteVelXOut),
        .o_vel_y       (whiteVelYOut),
        .o_vel_load    (whiteVelLoad),
        .o_state       (whiteState),
        .o_hole_num    (whiteHoleNum),
        .o_respawn     (whiteRespawn)
    );

    collision_ball #(.HOLE_SINK_FRAMES(HOLE_SINK_FRAMES)) u_red (
        .clk           (clk),
        .resetN        (resetN),
        .i_sof         (startOfFrame),
        .i_border_req  (redBorderReq),
        .i_border_vel_x(redBorderVelX),
        .i_border_vel_y(redBorderVelY),
        .i_bb_req      (ballBallReq),
        .i_bb_vel_x    (ballBallRedVelX),
        .i_bb_vel_y    (ballBallRedVelY),
        .i_hole_req    (redHoleReq),
        .i_hole_idx    (redHoleIdx),
        .i_respawn_req (redRespawnReq),
        .o_vel_x       (redVelXOut),
        .o_vel_y       (redVelYOut),
        .o_vel_load    (redVelLoad),
        .o_state       (redState),
        .o_hole_num    (redHoleNum),
        .o_respawn     (redRespawn)
    );
endmodule

`default_nettype wire

// File: doc/collision_scheduler.md
COLLISION_SCHEDULER -- requirements
Module: collision_scheduler

Interface
REQ-001 Parameter HOLE_SINK_FRAMES, default 16, means the number of frames a pocketed ball stays in SINKING (range 1..255).
REQ-002 clk  in  1  system clock; all logic SHALL be clocked on its rising edge only.
REQ-003 resetN  in  1  reset, synchronous, active-low.
REQ-004 startOfFrame  in  1  one-cycle pulse marking the frame boundary.
REQ-005 whiteBorderReq, redBorderReq  in  1 each  border collision detected this cycle.
REQ-006 whiteBorderVelX/Y, redBorderVelX/Y  in  11 signed each  post-border-bounce velocity, valid with the matching Req.
REQ-007 ballBallReq  in  1  white-red collision detected this cycle (applies to both balls).
REQ-008 ballBallWhiteVelX/Y, ballBallRedVelX/Y  in  11 signed each  post-impact velocities, valid with ballBallReq.
REQ-009 whiteHoleReq, redHoleReq  in  1 each  ball overlaps a hole this cycle; whiteHoleIdx, redHoleIdx  in  3 each  hole number 0..5.
REQ-010 whiteRespawnReq, redRespawnReq  in  1 each  game logic requests the ball back on the table.
REQ-011 whiteVelXOut/YOut, redVelXOut/YOut  out  11 signed each  velocity to load into the ball.
REQ-012 whiteVelLoad, redVelLoad  out  1 each  one-cycle strobe; ball SHALL load VelXOut/YOut when high.
REQ-013 whiteState, redState  out  2 each  00 ACTIVE, 01 SINKING, 10 POCKETED.
REQ-014 whiteHoleNum, redHoleNum  out  3 each  latched hole index of the last pocketing.
REQ-015 whiteRespawn, redRespawn  out  1 each  one-cycle strobe on return to ACTIVE.

Function (per ball b in {white, red}; the two instances are independent except for the shared ballBallReq)
REQ-016 Each ball SHALL hold a sticky pending-collision flag, a pending 11-bit X/Y velocity, a pending-hole flag and a pending hole index.
REQ-017 In ACTIVE, with no startOfFrame that cycle and the flag clear, ballBallReq SHALL set the flag and capture the ball-ball velocity; otherwise bBorderReq SHALL set it and capture the border velocity.
REQ-018 If ballBallReq and bBorderReq are high together, ball-ball SHALL win.
REQ-019 Once the flag is set, further collision requests SHALL be ignored until the next startOfFrame (first event per frame wins).
REQ-020 In ACTIVE, bHoleReq SHALL set the pending-hole flag and capture bHoleIdx only if the hole flag is clear.
REQ-021 On startOfFrame, a set hole flag SHALL move the ball to SINKING, set bHoleNum to the pending index and clear the frame counter.
REQ-022 In that same case, on the next cycle bVelLoad SHALL pulse with both velocity outputs 0.
REQ-023 On startOfFrame with the hole flag clear and the collision flag set, bVelLoad SHALL pulse the next cycle with the pending velocity on bVelXOut/YOut.
REQ-024 Latency from startOfFrame to VelLoad SHALL be exactly 1 cycle.
REQ-025 VelXOut/YOut SHALL hold their last value between strobes.
REQ-026 Both pending flags SHALL clear on every startOfFrame.
REQ-027 Requests arriving in the startOfFrame cycle SHALL be latched for the following frame, after the clear.
REQ-028 SINKING SHALL increment the frame counter on each startOfFrame.
REQ-029 When the counter reaches HOLE_SINK_FRAMES, SINKING SHALL go to POCKETED.
REQ-030 In SINKING and POCKETED, all collision and hole requests for that ball SHALL be ignored and no VelLoad SHALL be issued, except the zero-load of REQ-022.
REQ-031 POCKETED with bRespawnReq SHALL go to ACTIVE next cycle and pulse bRespawn for exactly one cycle.
REQ-032 bRespawnReq SHALL be ignored in ACTIVE and SINKING.
REQ-033 ballBallReq SHALL be applied only to balls in ACTIVE; the other ball's capture SHALL proceed unaffected.

Reset
REQ-034 resetN low at a rising clk edge SHALL force both balls to ACTIVE and clear all flags and counters.
REQ-035 During reset all outputs SHALL be 0: velocities, VelLoad, State, HoleNum and Respawn.
REQ-036 Reset asserted mid-SINKING or mid-frame SHALL discard pending events, with no VelLoad or Respawn strobe afterwards.

Verification
REQ-037 Border only: whiteBorderReq with vel (5,-3) mid-frame, then startOfFrame -> whiteVelLoad pulses 1 cycle later with (5,-3); redVelLoad stays 0.
REQ-038 Priority: same cycle whiteBorderReq (1,1) + ballBallReq white (-4,2) -> load (-4,2); a later border req in that frame with (9,9) is ignored.
REQ-039 Hole: redHoleReq idx 3 plus a collision in the same frame, then startOfFrame -> redVelLoad with (0,0), redState=01, redHoleNum=3.
REQ-039 (cont.) After HOLE_SINK_FRAMES=2 further startOfFrame pulses -> redState=10; redRespawnReq -> redRespawn 1-cycle pulse, redState=00.
REQ-040 Boundary: whiteBorderReq coincident with startOfFrame -> no load on that boundary; load occurs at the next startOfFrame.
REQ-041 Reset: resetN low for 1 cycle during SINKING -> all outputs 0, state ACTIVE, no strobe on the next startOfFrame.
